// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the key-press detector: state encodings, key count
// and debounce counter sizing.
package detector_jogada_pkg;

  localparam int unsigned NUM_CHAVES = 4;

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    FILTRANDO     = 3'd1,
    ACEITA        = 3'd2,
    INVALIDA      = 3'd3,
    ESPERA_SOLTAR = 3'd4
  } estado_t;

  // Counter only has to reach DEBOUNCE_CICLOS-1, so 255 fits in 8 bits.
  function automatic int unsigned largura_contador(input int unsigned ciclos);
    if (ciclos <= 1) return 1;
    return $clog2(ciclos);
  endfunction

  function automatic logic um_quente(input logic [NUM_CHAVES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs, cleared by async active-low reset.
module sincronizador_2ff #(
  parameter int unsigned LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// Key-press detector: synchronizes chaves, optionally debounces (DETECTOR_DEBOUNCE_EN),
// emits one pulse per press (valid one-hot or invalid multi-key) and waits for release.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  habilita,
  input  logic [NUM_CHAVES-1:0] chaves,
  output logic                  jogada_feita,
  output logic [NUM_CHAVES-1:0] jogada,
  output logic                  jogada_invalida,
  output logic [2:0]            db_estado
);

  if (DEBOUNCE_CICLOS < 1 || DEBOUNCE_CICLOS > 255) begin : g_param_invalido
    $error("DEBOUNCE_CICLOS must be in 1..255");
  end

  estado_t               estado, estado_next;
  logic [NUM_CHAVES-1:0] s, amostra, amostra_next;

`ifdef DETECTOR_DEBOUNCE_EN
  localparam int unsigned     CW       = largura_contador(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0]   CONT_FIM = CW'(DEBOUNCE_CICLOS - 1);
  logic [CW-1:0] contador, contador_next;
`endif

  sincronizador_2ff #(.LARGURA(NUM_CHAVES)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (chaves),
    .q     (s)
  );

  always_comb begin
    estado_next  = estado;
    amostra_next = amostra;
`ifdef DETECTOR_DEBOUNCE_EN
    contador_next = contador;
`endif
    case (estado)
      OCIOSO: begin
        if (habilita && s != '0) begin
          amostra_next = s;
`ifdef DETECTOR_DEBOUNCE_EN
          contador_next = '0;
          estado_next   = FILTRANDO;
`else
          estado_next   = um_quente(s) ? ACEITA : INVALIDA;
`endif
        end
      end
`ifdef DETECTOR_DEBOUNCE_EN
      FILTRANDO: begin
        if (!habilita || s != amostra) begin
          estado_next = OCIOSO;
        end else begin
          contador_next = contador + 1'b1;
          if (contador == CONT_FIM) estado_next = um_quente(amostra) ? ACEITA : INVALIDA;
        end
      end
`endif
      ACEITA:        estado_next = ESPERA_SOLTAR;
      INVALIDA:      estado_next = ESPERA_SOLTAR;
      ESPERA_SOLTAR: if (s == '0) estado_next = OCIOSO;
      default:       estado_next = OCIOSO;
    endcase
  end

  // jogada takes amostra_next so the no-debounce path (capture and accept on
  // the same edge) loads the freshly captured code.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= OCIOSO;
      amostra <= '0;
      jogada  <= '0;
`ifdef DETECTOR_DEBOUNCE_EN
      contador <= '0;
`endif
    end else begin
      estado  <= estado_next;
      amostra <= amostra_next;
      if (estado_next == ACEITA && estado != ACEITA) jogada <= amostra_next;
`ifdef DETECTOR_DEBOUNCE_EN
      contador <= contador_next;
`endif
    end
  end

  assign jogada_feita    = (estado == ACEITA);
  assign jogada_invalida = (estado == INVALIDA);
  assign db_estado       = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada against a press-level reference model.
module tb_detector_jogada;

  localparam int unsigned D = 1;
`ifdef DETECTOR_DEBOUNCE_EN
  localparam int unsigned RUN = D + 1;
  localparam int          LAT = D + 3;
  localparam int          BOUNCE_PULSES = 1;
  localparam int          PRE_RESET_PULSES = 0;
`else
  localparam int unsigned RUN = 1;
  localparam int          LAT = 3;
  localparam int          BOUNCE_PULSES = 2;
  localparam int          PRE_RESET_PULSES = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       habilita = 1'b0;
  logic [3:0] chaves = 4'b0;
  logic       jogada_feita, jogada_invalida;
  logic [3:0] jogada;
  logic [2:0] db_estado;

  int errors = 0;
  int checks = 0;

  detector_jogada #(.DEBOUNCE_CICLOS(D)) dut (
    .clock           (clock),
    .reset           (reset),
    .habilita        (habilita),
    .chaves          (chaves),
    .jogada_feita    (jogada_feita),
    .jogada          (jogada),
    .jogada_invalida (jogada_invalida),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  // Reference: a press fires after RUN consecutive equal nonzero synchronized
  // samples with habilita high; afterwards nothing until the synchronized input reads zero.
  logic [3:0]  q1 = '0, q2 = '0, cand = '0, exp_jog = '0, sv;
  int unsigned run = 0;
  bit          waiting = 0, exp_feita = 0, exp_inv = 0;
  logic [2:0]  exp_est = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q1 = '0; q2 = '0; cand = '0; exp_jog = '0; run = 0;
      waiting = 0; exp_feita = 0; exp_inv = 0; exp_est = '0;
    end else begin
      sv = q2; q2 = q1; q1 = chaves;
      if (exp_feita || exp_inv) begin
        exp_feita = 0; exp_inv = 0; waiting = 1;
      end else if (waiting) begin
        waiting = (sv != 0);
      end else begin
        if (run > 0 && (!habilita || sv != cand)) run = 0;
        else if (run > 0) run++;
        else if (habilita && sv != 0) begin cand = sv; run = 1; end
        if (run == RUN) begin
          run = 0;
          if ($countones(cand) == 1) begin exp_feita = 1; exp_jog = cand; end
          else exp_inv = 1;
        end
      end
      exp_est = exp_feita ? 3'd2 : exp_inv ? 3'd3 : waiting ? 3'd4 : (run > 0) ? 3'd1 : 3'd0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 0; habilita = 0; chaves = '0;
    @(negedge clock);
    checks++;
    if ({jogada_feita, jogada_invalida, jogada, db_estado} !== 9'b0) begin
      errors++;
      $display("FAIL reset_hold got f=%b i=%b j=%b e=%0d want all 0", jogada_feita, jogada_invalida, jogada, db_estado);
    end
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if ({jogada_feita, jogada_invalida, jogada, db_estado} !== 9'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got f=%b i=%b j=%b e=%0d want all 0", i, jogada_feita, jogada_invalida, jogada, db_estado);
      end
    end
  endtask

  task automatic test_valid_press();
    logic [4:0] q[$];
    int nf = 0, first = -1;
    for (int i = 0; i < 3; i++) q.push_back({1'b1, 4'b0100});
    for (int i = 0; i < 6; i++) q.push_back({1'b1, 4'b0000});
    for (int i = 0; i < q.size(); i++) begin
      {habilita, chaves} = q[i];
      @(negedge clock);
      checks++;
      if ({jogada_feita, jogada_invalida, jogada, db_estado} !== {exp_feita, exp_inv, exp_jog, exp_est}) begin
        errors++;
        $display("FAIL valid_press cyc%0d got f=%b i=%b j=%b e=%0d want f=%b i=%b j=%b e=%0d",
                 i, jogada_feita, jogada_invalida, jogada, db_estado, exp_feita, exp_inv, exp_jog, exp_est);
      end
      if (jogada_feita) begin nf++; if (first < 0) first = i; end
    end
    checks++;
    if (nf !== 1 || first !== LAT - 1) begin
      errors++;
      $display("FAIL press_latency got pulses=%0d at idx %0d want 1 at idx %0d", nf, first, LAT - 1);
    end
    checks++;
    if (jogada !== 4'b0100) begin
      errors++;
      $display("FAIL press_hold got jogada=%b want 0100", jogada);
    end
    q.delete(); nf = 0;
    for (int i = 0; i < 3; i++) q.push_back({1'b1, 4'b0001});
    for (int i = 0; i < 6; i++) q.push_back({1'b1, 4'b0000});
    for (int i = 0; i < q.size(); i++) begin
      {habilita, chaves} = q[i];
      @(negedge clock);
      checks++;
      if ({jogada_feita, jogada_invalida, jogada, db_estado} !== {exp_feita, exp_inv, exp_jog, exp_est}) begin
        errors++;
        $display("FAIL second_press cyc%0d got f=%b i=%b j=%b e=%0d want f=%b i=%b j=%b e=%0d",
                 i, jogada_feita, jogada_invalida, jogada, db_estado, exp_feita, exp_inv, exp_jog, exp_est);
      end
      nf += int'(jogada_feita);
    end
    checks++;
    if (nf !== 1 || jogada !== 4'b0001) begin
      errors++;
      $display("FAIL second_press_result got pulses=%0d jogada=%b want 1 and 0001", nf, jogada);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] q[$];
    int nf = 0;
    for (int i = 0; i < 6; i++) q.push_back({1'b1, (i % 2 == 0) ? 4'b0010 : 4'b0000});
    for (int i = 0; i < 3; i++) q.push_back({1'b1, 4'b0010});
    for (int i = 0; i < 6; i++) q.push_back({1'b1, 4'b0000});
    for (int i = 0; i < q.size(); i++) begin
      {habilita, chaves} = q[i];
      @(negedge clock);
      checks++;
      if ({jogada_feita, jogada_invalida, jogada, db_estado} !== {exp_feita, exp_inv, exp_jog, exp_est}) begin
        errors++;
        $display("FAIL bounce cyc%0d got f=%b i=%b j=%b e=%0d want f=%b i=%b j=%b e=%0d",
                 i, jogada_feita, jogada_invalida, jogada, db_estado, exp_feita, exp_inv, exp_jog, exp_est);
      end
      nf += int'(jogada_feita);
    end
    checks++;
    if (nf !== BOUNCE_PULSES || jogada !== 4'b0010) begin
      errors++;
      $display("FAIL bounce_result got pulses=%0d jogada=%b want %0d and 0010", nf, jogada, BOUNCE_PULSES);
    end
  endtask

  task automatic test_multi_hold();
    logic [4:0] q[$];
    int nf = 0, ni = 0, both = 0;
    for (int i = 0; i < 3; i++)  q.push_back({1'b1, 4'b0110});
    for (int i = 0; i < 6; i++)  q.push_back({1'b1, 4'b0000});
    for (int i = 0; i < 50; i++) q.push_back({1'b1, 4'b1000});
    for (int i = 0; i < 6; i++)  q.push_back({1'b1, 4'b0000});
    for (int i = 0; i < 3; i++)  q.push_back({1'b1, 4'b1000});
    for (int i = 0; i < 6; i++)  q.push_back({1'b1, 4'b0000});
    for (int i = 0; i < q.size(); i++) begin
      {habilita, chaves} = q[i];
      @(negedge clock);
      checks++;
      if ({jogada_feita, jogada_invalida, jogada, db_estado} !== {exp_feita, exp_inv, exp_jog, exp_est}) begin
        errors++;
        $display("FAIL multi_hold cyc%0d got f=%b i=%b j=%b e=%0d want f=%b i=%b j=%b e=%0d",
                 i, jogada_feita, jogada_invalida, jogada, db_estado, exp_feita, exp_inv, exp_jog, exp_est);
      end
      if (i == 8 && jogada !== 4'b0010) begin
        errors++;
        $display("FAIL invalid_keeps_jogada got %b want 0010", jogada);
      end
      nf += int'(jogada_feita); ni += int'(jogada_invalida);
      both += int'(jogada_feita && jogada_invalida);
    end
    checks++;
    if (nf !== 2 || ni !== 1 || both !== 0 || jogada !== 4'b1000) begin
      errors++;
      $display("FAIL multi_hold_result got feita=%0d inval=%0d both=%0d jogada=%b want 2 1 0 1000", nf, ni, both, jogada);
    end
  endtask

  task automatic test_gating();
    int pulses = 0, busy = 0;
    for (int i = 0; i < 16; i++) begin
      habilita = 0; chaves = (i < 10) ? 4'b0001 : 4'b0000;
      @(negedge clock);
      checks++;
      if ({jogada_feita, jogada_invalida, jogada, db_estado} !== {exp_feita, exp_inv, exp_jog, exp_est}) begin
        errors++;
        $display("FAIL gating cyc%0d got f=%b i=%b j=%b e=%0d want f=%b i=%b j=%b e=%0d",
                 i, jogada_feita, jogada_invalida, jogada, db_estado, exp_feita, exp_inv, exp_jog, exp_est);
      end
      pulses += int'(jogada_feita || jogada_invalida);
      busy += int'(db_estado != 3'd0);
    end
    checks++;
    if (pulses !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL gating_result got pulses=%0d nonidle=%0d want 0 0", pulses, busy);
    end
  endtask

  task automatic test_async_reset();
    int nf = 0;
    habilita = 1; chaves = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      nf += int'(jogada_feita);
    end
    checks++;
    if (nf !== PRE_RESET_PULSES) begin
      errors++;
      $display("FAIL pre_reset_pulses got %0d want %0d", nf, PRE_RESET_PULSES);
    end
    #2 reset = 0;
    #1;
    checks++;
    if ({jogada_feita, jogada_invalida, jogada, db_estado} !== 9'b0) begin
      errors++;
      $display("FAIL async_reset got f=%b i=%b j=%b e=%0d want all 0", jogada_feita, jogada_invalida, jogada, db_estado);
    end
    @(negedge clock);
    reset = 1;
    for (int i = 0; i < 14; i++) begin
      chaves = (i < 6) ? 4'b0001 : 4'b0000;
      @(negedge clock);
      checks++;
      if ({jogada_feita, jogada_invalida, jogada, db_estado} !== {exp_feita, exp_inv, exp_jog, exp_est}) begin
        errors++;
        $display("FAIL after_reset cyc%0d got f=%b i=%b j=%b e=%0d want f=%b i=%b j=%b e=%0d",
                 i, jogada_feita, jogada_invalida, jogada, db_estado, exp_feita, exp_inv, exp_jog, exp_est);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 120; k++) begin
      logic [3:0] v;
      int unsigned len;
      logic h;
      case ($urandom_range(0, 3))
        0:       v = 4'b0;
        1, 2:    v = 4'b0001 << $urandom_range(0, 3);
        default: v = 4'($urandom);
      endcase
      len = $urandom_range(1, 5);
      h = ($urandom_range(0, 7) != 0);
      for (int unsigned j = 0; j < len; j++) begin
        habilita = h; chaves = v;
        @(negedge clock);
        checks++;
        if ({jogada_feita, jogada_invalida, jogada, db_estado} !== {exp_feita, exp_inv, exp_jog, exp_est}) begin
          errors++;
          $display("FAIL random blk%0d got f=%b i=%b j=%b e=%0d want f=%b i=%b j=%b e=%0d",
                   k, jogada_feita, jogada_invalida, jogada, db_estado, exp_feita, exp_inv, exp_jog, exp_est);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_press();
    test_bounce();
    test_multi_hold();
    test_gating();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
# detector_jogada

Input-conditioning stage that sits directly upstream of the game datapath/FSM of `circuito_exp5`. It samples the raw 4-bit `chaves` switch bus, synchronizes it, and filters bounce. It emits a single-cycle `jogada_feita` pulse with a held one-hot `jogada` code for each valid press, and a `jogada_invalida` pulse when more than one key is pressed. It then waits for full release before arming again, so the downstream comparator sees exactly one event per physical press.

## Interface
- `DEBOUNCE_CICLOS`, default 1: number of consecutive cycles the synchronized value must stay unchanged before it is accepted; legal range 1..255.
- `clock` in 1: system clock, 50 MHz, rising edge.
- `reset` in 1: reset; one clock; reset is asynchronous and active-low.
- `habilita` in 1: high = new presses may be accepted; driven by the game FSM while waiting for a play.
- `chaves` in 4: raw, asynchronous key inputs.
- `jogada_feita` out 1: one-cycle pulse, valid one-hot press accepted.
- `jogada` out 4: last accepted one-hot code, held until the next acceptance.
- `jogada_invalida` out 1: one-cycle pulse, stable multi-key press rejected.
- `db_estado` out 3: current state encoding, for the 7-seg debug path.

## Operation
- Reset (`reset`=0, async) forces the following values immediately and holds them while low:
  - state OCIOSO;
  - sync flops 0000;
  - `amostra` 0000;
  - counter 0;
  - `jogada` 0000;
  - `jogada_feita`=0, `jogada_invalida`=0, `db_estado`=0.
- `chaves` passes through a 2-flop synchronizer. `s` = second-flop output; all decisions use `s` only.
- States and encodings:
  - OCIOSO (0):
    - if `habilita` and `s`≠0: `amostra`←`s`, counter←0, go to FILTRANDO.
    - otherwise stay in OCIOSO.
  - FILTRANDO (1):
    - if `habilita`=0 or `s`≠`amostra`: go to OCIOSO (bounce or abort, no pulse).
    - otherwise counter+1. When counter reaches `DEBOUNCE_CICLOS`-1, go to ACEITA if `amostra` is one-hot, else go to INVALIDA.
  - ACEITA (2):
    - `jogada_feita`=1 for this cycle only; `jogada` is loaded from `amostra` on entry.
    - go to ESPERA_SOLTAR unconditionally.
  - INVALIDA (3):
    - `jogada_invalida`=1 for this cycle only; `jogada` is unchanged.
    - go to ESPERA_SOLTAR unconditionally.
  - ESPERA_SOLTAR (4):
    - stay while `s`≠0; go to OCIOSO when `s`=0.
    - `habilita` is ignored in this state.
- Encodings 5–7 are unreachable and recover to OCIOSO on the next edge.
- `jogada_feita` and `jogada_invalida` are never high together.
- `jogada` changes only on entry to ACEITA.
- Holding a key down forever yields exactly one pulse.
- `habilita` dropping during ACEITA or INVALIDA does not cancel the pulse.

## Timing
- Let E0 be the first rising edge that samples a new stable `chaves` value. Then:
  - `s` is valid after E0+1;
  - FILTRANDO is entered after E0+2;
  - `jogada_feita`/`jogada_invalida` are high during the cycle after edge E0+2+`DEBOUNCE_CICLOS`.
- With default 1: the pulse occurs after E0+3, which needs `chaves` held for ≥2 edges; the bench's 3-cycle press passes.
- `jogada` is valid in the same cycle as `jogada_feita`; outputs are registered or decoded from the state register, with no combinational path from `chaves`.
- Re-arm after release: OCIOSO is reached 2 edges after `chaves` returns to 0000 (synchronizer plus one state edge).
- A `reset` assertion during ACEITA kills the pulse immediately (asynchronous).

## Configuration
- `DETECTOR_DEBOUNCE_EN` defined: FILTRANDO and its counter are present, as described above.
- `DETECTOR_DEBOUNCE_EN` not defined:
  - FILTRANDO and the counter are removed; OCIOSO goes directly to ACEITA/INVALIDA using `s` captured into `amostra`.
  - The pulse occurs after E0+2.
  - `DEBOUNCE_CICLOS` is ignored.
  - `db_estado` encodings are unchanged.

## Structure
- Shared package/header `detector_jogada_pkg`:
  - state encodings `OCIOSO`..`ESPERA_SOLTAR` (3 bits);
  - `NUM_CHAVES`=4;
  - counter width derived from `DEBOUNCE_CICLOS` (8 bits max).
- Sub-module `sincronizador_2ff`: parameterized width, async active-low reset to 0. Instantiated once for `chaves`.
- The FSM and counter live in `detector_jogada` proper.

## Test plan
- Reset then idle: `reset`=0 for 1 cycle, `chaves`=0000 → all outputs 0, `db_estado`=0; `reset`=1 with `chaves`=0000 → outputs unchanged.
- Valid press: `habilita`=1, `chaves`=0100 for 3 cycles → exactly one `jogada_feita` pulse 4 edges after the first sample, `jogada`=0100 held; a second press of 0001 → `jogada`=0001.
- Bounce: `chaves` alternates 0010/0000 every cycle for 6 cycles, then 0010 for 3 cycles → exactly one pulse, `jogada`=0010.
- Multi-key and hold: `chaves`=0110 for 3 cycles → one `jogada_invalida` pulse, `jogada` unchanged. Then `chaves`=1000 held 50 cycles → one `jogada_feita` pulse only; release, press again → second pulse.
- Gating and reset: `habilita`=0 with `chaves`=0001 → no pulses, state stays 0. Async `reset`=0 asserted mid-FILTRANDO → state 0 and no pulse. Rebuild without `DETECTOR_DEBOUNCE_EN` → pulse 3 edges after the first sample.
